fetch_sequencer: RTL and testbench

- Controller that sequences the IFU PC register against a variable-latency instruction memory with a req/ack handshake.
- Drives the IFU's freezePC input so PC advances only when an instruction is actually delivered or a redirect is taken.
- Buffers one returned instruction when decode stalls.
- Sits between IFU, instruction memory and the IF/ID boundary.

---
 rtl/fetch_sequencer.sv | 94 +++++++++
 tb/tb_fetch_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences IFU PC and a req/ack instruction memory, buffering one word on decode stall.
// Optional FETCH_TIMEOUT_EN aborts fetches outstanding for TIMEOUT_CYCLES cycles and flags timeout_err.
module fetch_sequencer #(
  parameter int FLUSH_ON_REDIRECT = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        redirect,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        freeze_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state, state_n;
  logic [31:0] hold_buf;
  logic ok, deliver, from_hold, capture, timeout;
  assign ok = !if_valid || !id_stall;
  assign imem_req = state == S_WAIT || state == S_DROP;
  assign busy = imem_req;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = imem_req && !imem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (imem_req && state_n == state) ? cnt + 1'b1 : '0;
      if (timeout) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    deliver = 1'b0;
    from_hold = 1'b0;
    capture = 1'b0;
    case (state)
      S_ISSUE: state_n = redirect ? S_ISSUE : S_WAIT;
      S_WAIT: begin
        if (redirect) state_n = imem_ack ? S_ISSUE : S_DROP;
        else if (imem_ack) begin
          deliver = ok;
          capture = !ok;
          state_n = ok ? S_ISSUE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) state_n = S_ISSUE;
        else if (ok) begin
          deliver = 1'b1;
          from_hold = 1'b1;
          state_n = S_ISSUE;
        end
      end
      default: if (!redirect && imem_ack) state_n = S_ISSUE;
    endcase
    if (timeout) state_n = S_ISSUE;
    freeze_pc = !(redirect || deliver);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_ISSUE;
      imem_addr <= '0;
      hold_buf <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
    end else begin
      state <= state_n;
      if (state == S_ISSUE) imem_addr <= pc_in;
      if (capture) hold_buf <= imem_rdata;
      if (deliver) begin
        if_instr <= from_hold ? hold_buf : imem_rdata;
        if_pc <= imem_addr;
        if_valid <= 1'b1;
      end else if ((FLUSH_ON_REDIRECT != 0 && redirect) || !id_stall) if_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer (FLUSH_ON_REDIRECT=1, TIMEOUT_CYCLES=4).
module tb_fetch_sequencer;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc_in = '0, imem_rdata = '0, imem_addr, if_instr, if_pc;
  logic redirect = 1'b0, id_stall = 1'b0, imem_ack = 1'b0;
  logic imem_req, freeze_pc, if_valid, busy, timeout_err;
  int total = 0, bad = 0;
  fetch_sequencer #(.FLUSH_ON_REDIRECT(1), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .redirect(redirect), .id_stall(id_stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .freeze_pc(freeze_pc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (2) step();
    total++; if ({imem_req, busy, freeze_pc, if_valid, timeout_err} !== 5'b00100) begin bad++; $display("FAIL reset_flags got=%b exp=00100", {imem_req, busy, freeze_pc, if_valid, timeout_err}); end
    total++; if ({imem_addr, if_instr, if_pc} !== 96'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {imem_addr, if_instr, if_pc}); end
  endtask
  task automatic test_basic_fetch();
    pc_in = 32'h3000;
    reset = 1'b1;
    #1;
    total++; if (freeze_pc !== 1'b1) begin bad++; $display("FAIL issue_freeze got=%b exp=1", freeze_pc); end
    step();
    total++; if (imem_addr !== 32'h3000 || imem_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL wait_req got=%h/%b/%b exp=3000/1/1", imem_addr, imem_req, busy); end
    total++; if (freeze_pc !== 1'b1) begin bad++; $display("FAIL wait_freeze got=%b exp=1", freeze_pc); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'h24010001;
    #1;
    total++; if (freeze_pc !== 1'b0) begin bad++; $display("FAIL ack_freeze got=%b exp=0", freeze_pc); end
    step();
    imem_ack = 1'b0; pc_in = 32'h3004;
    total++; if (if_valid !== 1'b1 || if_instr !== 32'h24010001 || if_pc !== 32'h3000) begin bad++; $display("FAIL deliver1 got=%b/%h/%h exp=1/24010001/3000", if_valid, if_instr, if_pc); end
    #1;
    total++; if (freeze_pc !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL post_deliver got=%b/%b exp=1/0", freeze_pc, imem_req); end
  endtask
  task automatic test_hold();
    id_stall = 1'b1;
    step();
    total++; if (imem_addr !== 32'h3004) begin bad++; $display("FAIL hold_addr got=%h exp=3004", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h11112222;
    #1;
    total++; if (freeze_pc !== 1'b1) begin bad++; $display("FAIL hold_ack_freeze got=%b exp=1", freeze_pc); end
    step();
    imem_ack = 1'b0;
    total++; if (if_instr !== 32'h24010001 || if_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL hold_keep got=%h/%b/%b exp=24010001/1/0", if_instr, if_valid, imem_req); end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (freeze_pc !== 1'b1) begin bad++; $display("FAIL hold_stall_freeze cyc=%0d got=%b exp=1", i, freeze_pc); end
      if (i < 2) step();
    end
    id_stall = 1'b0;
    #1;
    total++; if (freeze_pc !== 1'b0) begin bad++; $display("FAIL hold_release_freeze got=%b exp=0", freeze_pc); end
    step();
    pc_in = 32'h3008;
    total++; if (if_instr !== 32'h11112222 || if_pc !== 32'h3004 || if_valid !== 1'b1) begin bad++; $display("FAIL hold_deliver got=%h/%h/%b exp=11112222/3004/1", if_instr, if_pc, if_valid); end
    #1;
    total++; if (freeze_pc !== 1'b1) begin bad++; $display("FAIL hold_after_freeze got=%b exp=1", freeze_pc); end
  endtask
  task automatic test_redirect_wait();
    step();
    redirect = 1'b1; pc_in = 32'h4000;
    #1;
    total++; if (freeze_pc !== 1'b0) begin bad++; $display("FAIL redir_freeze got=%b exp=0", freeze_pc); end
    step();
    redirect = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin bad++; $display("FAIL drop_req got=%b/%h exp=1/3008", imem_req, imem_addr); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    total++; if (freeze_pc !== 1'b1) begin bad++; $display("FAIL drop_ack_freeze got=%b exp=1", freeze_pc); end
    step();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0 || if_instr === 32'hDEADBEEF || imem_req !== 1'b0) begin bad++; $display("FAIL drop_discard got=%b/%h/%b exp=0/not-deadbeef/0", if_valid, if_instr, imem_req); end
    step();
    total++; if (imem_addr !== 32'h4000) begin bad++; $display("FAIL redir_addr got=%h exp=4000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h8C220000;
    step();
    imem_ack = 1'b0;
    total++; if (if_instr !== 32'h8C220000 || if_pc !== 32'h4000 || if_valid !== 1'b1) begin bad++; $display("FAIL redir_deliver got=%h/%h/%b exp=8c220000/4000/1", if_instr, if_pc, if_valid); end
  endtask
  task automatic test_redirect_ack();
    id_stall = 1'b1; pc_in = 32'h5000;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hBADC0DE0; redirect = 1'b1; pc_in = 32'h6000;
    #1;
    total++; if (freeze_pc !== 1'b0) begin bad++; $display("FAIL redir_ack_freeze got=%b exp=0", freeze_pc); end
    step();
    imem_ack = 1'b0; redirect = 1'b0;
    total++; if (if_valid !== 1'b0 || if_instr !== 32'h8C220000 || imem_req !== 1'b0) begin bad++; $display("FAIL redir_ack_flush got=%b/%h/%b exp=0/8c220000/0", if_valid, if_instr, imem_req); end
    step();
    id_stall = 1'b0;
    total++; if (imem_addr !== 32'h6000 || imem_req !== 1'b1) begin bad++; $display("FAIL redir_ack_next got=%h/%b exp=6000/1", imem_addr, imem_req); end
  endtask
  task automatic test_reset_mid_fetch();
    #2 reset = 1'b0;
    #1;
    total++; if ({imem_req, busy, freeze_pc, if_valid} !== 4'b0010 || {imem_addr, if_instr, if_pc} !== 96'h0) begin bad++; $display("FAIL async_reset got=%b/%h exp=0010/0", {imem_req, busy, freeze_pc, if_valid}, {imem_addr, if_instr, if_pc}); end
    step();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h77777777; pc_in = 32'h7000;
    #1;
    total++; if (freeze_pc !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL stray_ack got=%b/%b exp=1/0", freeze_pc, imem_req); end
    step();
    imem_ack = 1'b0;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h7000) begin bad++; $display("FAIL stray_ignored got=%b/%b/%h exp=0/1/7000", if_valid, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    step();
    imem_ack = 1'b0;
    total++; if (if_instr !== 32'h12345678 || if_valid !== 1'b1) begin bad++; $display("FAIL post_reset_fetch got=%h/%b exp=12345678/1", if_instr, if_valid); end
  endtask
  task automatic test_timeout();
    reset = 1'b0;
    step();
    reset = 1'b1; pc_in = 32'h8000;
    step();
`ifdef FETCH_TIMEOUT_EN
    repeat (3) step();
    total++; if (timeout_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL to_before got=%b/%b exp=0/1", timeout_err, imem_req); end
    step();
    total++; if (timeout_err !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL to_fire got=%b/%b/%b exp=1/0/0", timeout_err, imem_req, if_valid); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE0001;
    step();
    imem_ack = 1'b0;
    total++; if (timeout_err !== 1'b1 || if_instr !== 32'hCAFE0001 || if_valid !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b/%h/%b exp=1/cafe0001/1", timeout_err, if_instr, if_valid); end
`else
    repeat (20) step();
    total++; if (timeout_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL no_to_wait got=%b/%b exp=0/1", timeout_err, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE0001;
    step();
    imem_ack = 1'b0;
    total++; if (timeout_err !== 1'b0 || if_instr !== 32'hCAFE0001 || if_valid !== 1'b1) begin bad++; $display("FAIL no_to_deliver got=%b/%h/%b exp=0/cafe0001/1", timeout_err, if_instr, if_valid); end
`endif
  endtask
  initial begin
    test_reset();
    test_basic_fetch();
    test_hold();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid_fetch();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
